// File: rtl/dmem_if.sv
// Request/response bundle between the MEM pipeline stage and the data-memory controller.
// The master modport belongs to the requester and the slave modport belongs to the controller.
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault
  );
endinterface

// File: rtl/dmem_ctrl.sv
// RV32I data-memory controller: byte-enabled word RAM with fault checks and programmable wait states.
// Optional saturating fault counter on port fault_count when DMEM_FAULT_CNT_EN is defined.
module dmem_ctrl #(
  parameter int    ADDR_W      = 20,
  parameter int    WAIT_STATES = 0,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst,
  dmem_if.slave       bus
`ifdef DMEM_FAULT_CNT_EN
  ,
  output logic [15:0] fault_count
`endif
);

  localparam int         DEPTH = 2 ** (ADDR_W - 2);
  localparam logic [3:0] WS    = WAIT_STATES[3:0];

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state;
  logic [3:0]  wcnt;
  logic        l_we;
  logic [2:0]  l_f3;
  logic [31:0] l_addr;
  logic [31:0] l_wdata;

  logic [31:0] mem [DEPTH];

  // In IDLE the access is taken straight from the bus so a zero-wait request
  // can commit on its accept edge; afterwards only the latched copy matters.
  logic        a_we;
  logic [2:0]  a_f3;
  logic [31:0] a_addr;
  logic [31:0] a_wdata;
  assign a_we    = (state == S_IDLE) ? bus.req_we     : l_we;
  assign a_f3    = (state == S_IDLE) ? bus.req_funct3 : l_f3;
  assign a_addr  = (state == S_IDLE) ? bus.req_addr   : l_addr;
  assign a_wdata = (state == S_IDLE) ? bus.req_wdata  : l_wdata;

  logic accept, commit;
  assign accept = (state == S_IDLE) && bus.req_valid && bus.req_ready;
  assign commit = (accept && WS == 4'd0) || (state == S_WAIT && wcnt == WS);

  logic range_bad, f3_bad, align_bad, fault;
  assign range_bad = (a_addr >> ADDR_W) != 32'd0;
  assign f3_bad    = a_we ? (a_f3 > 3'd2) : (a_f3 == 3'd3 || a_f3[2:1] == 2'b11);
  assign align_bad = (a_f3[1:0] == 2'b01 && a_addr[0]) ||
                     (a_f3[1:0] == 2'b10 && a_addr[1:0] != 2'b00);
  assign fault     = range_bad || f3_bad || align_bad;

  logic [ADDR_W-3:0] idx;
  assign idx = a_addr[ADDR_W-1:2];

  logic [3:0]  be;
  logic [31:0] wd;
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    be = 4'b1111;
    wd = a_wdata;
    case (a_f3[1:0])
      2'b00: begin be = 4'b0001 << a_addr[1:0];        wd = {4{a_wdata[7:0]}};  end
      2'b01: begin be = 4'b0011 << {a_addr[1], 1'b0}; wd = {2{a_wdata[15:0]}}; end
      default: ;
    endcase
  end

  logic [31:0] lane, ld_data;
  assign lane = mem[idx] >> {a_addr[1:0], 3'b000};
  always_comb begin
    ld_data = lane;
    case (a_f3)
      3'd0:    ld_data = {{24{lane[7]}},  lane[7:0]};
      3'd1:    ld_data = {{16{lane[15]}}, lane[15:0]};
      3'd4:    ld_data = {24'd0, lane[7:0]};
      3'd5:    ld_data = {16'd0, lane[15:0]};
      default: ;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      wcnt          <= 4'd0;
      bus.req_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= 32'd0;
      bus.rsp_fault <= 1'b0;
    end else begin
      bus.rsp_valid <= 1'b0;
      case (state)
        S_IDLE: if (accept) begin
          l_we          <= bus.req_we;
          l_f3          <= bus.req_funct3;
          l_addr        <= bus.req_addr;
          l_wdata       <= bus.req_wdata;
          bus.req_ready <= 1'b0;
          if (WS == 4'd0) begin
            state <= S_RESP;
          end else begin
            state <= S_WAIT;
            wcnt  <= 4'd1;
          end
        end
        S_WAIT: if (wcnt == WS) begin
          state <= S_RESP;
          wcnt  <= 4'd0;
        end else begin
          wcnt <= wcnt + 4'd1;
        end
        S_RESP: begin
          state         <= S_IDLE;
          bus.req_ready <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
      if (commit) begin
        bus.rsp_valid <= 1'b1;
        bus.rsp_fault <= fault;
        bus.rsp_rdata <= (fault || a_we) ? 32'd0 : ld_data;
      end
    end
  end

  // NOTE: the RAM array has no reset; it keeps committed stores across rst.
  always_ff @(posedge clk) begin
    if (!rst && commit && a_we && !fault) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wd[8*b +: 8];
      end
    end
  end

`ifdef DMEM_FAULT_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fault_count <= 16'd0;
    end else if (commit && fault && fault_count != 16'hFFFF) begin
      fault_count <= fault_count + 16'd1;
    end
  end
`endif

endmodule
